// File: rtl/regfile_mp_if.sv
// Register-file access bus: write port, two read ports and bulk-clear control/status.
interface regfile_mp_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic                  ctrl_writeEn;
    logic [ADDR_WIDTH-1:0] ctrl_writeReg;
    logic [DATA_WIDTH-1:0] data_writeReg;
    logic [ADDR_WIDTH-1:0] ctrl_readRegA;
    logic [ADDR_WIDTH-1:0] ctrl_readRegB;
    logic                  ctrl_clear;
    logic [DATA_WIDTH-1:0] data_readRegA;
    logic [DATA_WIDTH-1:0] data_readRegB;
    logic                  clear_busy;
    logic                  clear_done;
    logic                  write_dropped;

    modport master (
        output ctrl_writeEn, ctrl_writeReg, data_writeReg,
        output ctrl_readRegA, ctrl_readRegB, ctrl_clear,
        input  data_readRegA, data_readRegB,
        input  clear_busy, clear_done, write_dropped
    );

    modport slave (
        input  ctrl_writeEn, ctrl_writeReg, data_writeReg,
        input  ctrl_readRegA, ctrl_readRegB, ctrl_clear,
        output data_readRegA, data_readRegB,
        output clear_busy, clear_done, write_dropped
    );
endinterface

// File: rtl/regfile_mp.sv
// Two-read/one-write register file with a one-register-per-cycle bulk-clear sweep.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_MP_BYPASS_EN.
module regfile_mp #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter bit          ZERO_REG   = 1'b1
) (
    input  logic         clock,
    input  logic         ctrl_reset,
    regfile_mp_if.slave  bus
);
    localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ZERO_REG ? ADDR_WIDTH'(1) : '0;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] sweep_idx;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  busy_q;
    logic                  done_q;
    logic                  dropped_q;

    logic                  write_ok_c;
    logic [DATA_WIDTH-1:0] rd_a_c;
    logic [DATA_WIDTH-1:0] rd_b_c;

    // A write racing the clear request on the same edge is dropped, not committed.
    assign write_ok_c = bus.ctrl_writeEn && (state == IDLE) && !bus.ctrl_clear &&
                        (!ZERO_REG || (bus.ctrl_writeReg != '0));

    // Storage, sweep FSM and registered status flags.
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            state     <= IDLE;
            sweep_idx <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            dropped_q <= bus.ctrl_writeEn && ((state == CLEAR) || bus.ctrl_clear);
            case (state)
                IDLE: begin
                    if (bus.ctrl_clear) begin
                        state     <= CLEAR;
                        sweep_idx <= FIRST_IDX;
                        busy_q    <= 1'b1;
                    end else if (write_ok_c) begin
                        regs[bus.ctrl_writeReg] <= bus.data_writeReg;
                    end
                end
                CLEAR: begin
                    regs[sweep_idx] <= '0;
                    // Index holds at the last entry instead of wrapping.
                    if (sweep_idx == LAST_IDX) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        sweep_idx <= sweep_idx + ADDR_WIDTH'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Combinational read ports.
    always_comb begin
        rd_a_c = regs[bus.ctrl_readRegA];
        rd_b_c = regs[bus.ctrl_readRegB];
        if (ZERO_REG && (bus.ctrl_readRegA == '0)) rd_a_c = '0;
        if (ZERO_REG && (bus.ctrl_readRegB == '0)) rd_b_c = '0;
`ifdef REGFILE_MP_BYPASS_EN
        // Forward only data that will actually commit on the coming edge.
        if (write_ok_c && (bus.ctrl_readRegA == bus.ctrl_writeReg)) rd_a_c = bus.data_writeReg;
        if (write_ok_c && (bus.ctrl_readRegB == bus.ctrl_writeReg)) rd_b_c = bus.data_writeReg;
`endif
    end

    assign bus.data_readRegA = rd_a_c;
    assign bus.data_readRegB = rd_b_c;
    assign bus.clear_busy    = busy_q;
    assign bus.clear_done    = done_q;
    assign bus.write_dropped = dropped_q;
endmodule
